// File: rtl/rom_load_arbiter.sv
// ROM download sequencer: buffers ioctl words and arbitrates the SDRAM port between loader and core.
// Optional ROM_HDR_SKIP_EN: strips a 512-byte copier header from ROM files.

module rom_load_arbiter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ROM_INDEX  = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic [23:0] ioctl_filesize,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [23:0] core_addr,
  input  logic [15:0] core_din,
  output logic        core_ack,
  output logic [15:0] core_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  input  logic [15:0] mem_dout,
  output logic        core_reset,
  output logic [23:0] rom_mask,
  output logic        load_done,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;
  typedef enum logic [1:0] {P_IDLE, P_BUSY, P_GAP} port_t;

  state_t state_reg, state_next;
  port_t  port_reg, port_next;

  logic        wr_q, dl_q;
  logic        dl_rise, dl_fall;
  logic        load_start, load_finish;
  logic        issue_loader, issue_core;
  logic        grant_core_reg;
  logic        mem_req_reg, mem_we_reg;
  logic [23:0] mem_addr_reg;
  logic [15:0] mem_din_reg;
  logic        core_reset_reg, load_done_reg, overflow_reg;
  logic [23:0] rom_mask_reg;
  logic [24:0] max_addr_reg, push_word_end;

  logic        word_valid, hdr_drop;
  logic [23:0] hdr_off;
  logic        push_vld_reg, push_ok, pop;
  logic [23:0] push_addr_reg;
  logic [15:0] push_data_reg;

  logic [23:0] fifo_addr_mem [FIFO_DEPTH];
  logic [15:0] fifo_data_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_empty, fifo_full;
  logic        unused_inputs;

  assign unused_inputs = ^{ioctl_addr[0], ioctl_filesize};

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

`ifdef ROM_HDR_SKIP_EN
  logic hdr_skip_reg;

  always_ff @(posedge clk_sys) begin
    if (reset)
      hdr_skip_reg <= 1'b0;
    else if (load_start)
      hdr_skip_reg <= (ioctl_filesize[9:0] == 10'd512);
  end

  assign hdr_off  = hdr_skip_reg ? 24'd256 : 24'd0;
  assign hdr_drop = hdr_skip_reg && (ioctl_addr < 25'd512);
`else
  assign hdr_off  = 24'd0;
  assign hdr_drop = 1'b0;
`endif

  assign word_valid = (ioctl_wr != wr_q) && (state_reg == S_LOAD) && !hdr_drop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok    = push_vld_reg && !fifo_full;
  // The head entry stays in the FIFO until its write is acknowledged.
  assign pop        = (port_reg == P_BUSY) && !grant_core_reg && mem_ack;
  assign push_word_end = {1'b0, push_addr_reg} + 25'd1;

  function automatic logic [23:0] size_mask(input logic [24:0] words);
    logic [23:0] m;
    m = {words[22:0], 1'b0} - 24'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    if (words == 25'd0)
      return 24'd0;
    else if (words[24] || words[23])
      return 24'hFFFFFF;
    else
      return m;
  endfunction

  always_comb begin
    state_next   = state_reg;
    port_next    = port_reg;
    load_start   = 1'b0;
    load_finish  = 1'b0;
    issue_loader = 1'b0;
    issue_core   = 1'b0;
    case (state_reg)
      S_IDLE:
        if (dl_rise && ioctl_index == ROM_INDEX) begin
          state_next = S_LOAD;
          load_start = 1'b1;
        end
      S_LOAD:
        if (dl_fall)
          state_next = S_DRAIN;
      S_DRAIN:
        if (fifo_empty && !push_vld_reg) begin
          state_next  = S_IDLE;
          load_finish = 1'b1;
        end
      default: state_next = S_IDLE;
    endcase
    case (port_reg)
      P_IDLE:
        if (state_reg != S_IDLE && !fifo_empty) begin
          issue_loader = 1'b1;
          port_next    = P_BUSY;
        end else if (state_reg == S_IDLE && core_req) begin
          issue_core = 1'b1;
          port_next  = P_BUSY;
        end
      P_BUSY:
        if (mem_ack)
          port_next = P_GAP;
      P_GAP:
        port_next = P_IDLE;
      default: port_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    wr_q <= ioctl_wr;
    dl_q <= ioctl_download;
    if (reset) begin
      state_reg      <= S_IDLE;
      port_reg       <= P_IDLE;
      grant_core_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      core_reset_reg <= 1'b1;
      load_done_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      rom_mask_reg   <= 24'hFFFFFF;
      max_addr_reg   <= 25'd0;
      push_vld_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      port_reg      <= port_next;
      load_done_reg <= load_finish;
      push_vld_reg  <= word_valid;

      if (load_start)
        core_reset_reg <= 1'b1;
      else if (state_reg == S_IDLE)
        core_reset_reg <= 1'b0;

      if (load_finish)
        rom_mask_reg <= size_mask(max_addr_reg);

      if (load_start)
        overflow_reg <= 1'b0;
      else if (push_vld_reg && fifo_full)
        overflow_reg <= 1'b1;

      if (load_start)
        max_addr_reg <= 25'd0;
      else if (push_ok && push_word_end > max_addr_reg)
        max_addr_reg <= push_word_end;

      if (load_start) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_ok)
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      if (issue_loader) begin
        mem_req_reg    <= 1'b1;
        mem_we_reg     <= 1'b1;
        grant_core_reg <= 1'b0;
      end else if (issue_core) begin
        mem_req_reg    <= 1'b1;
        mem_we_reg     <= core_we;
        grant_core_reg <= 1'b1;
      end else if (port_reg == P_BUSY && mem_ack) begin
        mem_req_reg <= 1'b0;
        mem_we_reg  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    push_addr_reg <= ioctl_addr[24:1] - hdr_off;
    push_data_reg <= ioctl_dout;
    if (push_ok) begin
      fifo_addr_mem[wr_ptr_reg[AW-1:0]] <= push_addr_reg;
      fifo_data_mem[wr_ptr_reg[AW-1:0]] <= push_data_reg;
    end
    if (issue_loader) begin
      mem_addr_reg <= fifo_addr_mem[rd_ptr_reg[AW-1:0]];
      mem_din_reg  <= fifo_data_mem[rd_ptr_reg[AW-1:0]];
    end else if (issue_core) begin
      mem_addr_reg <= core_addr;
      mem_din_reg  <= core_din;
    end
  end

  assign core_ack   = (port_reg == P_BUSY) && grant_core_reg && mem_ack;
  assign core_dout  = mem_dout;
  assign mem_req    = mem_req_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign core_reset = core_reset_reg;
  assign rom_mask   = rom_mask_reg;
  assign load_done  = load_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed + randomized bench for rom_load_arbiter with an SDRAM responder and a word-list scoreboard.

module tb_rom_load_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic [23:0] ioctl_filesize = '0;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [23:0] core_addr = '0;
  logic [15:0] core_din = '0;
  logic        core_ack;
  logic [15:0] core_dout;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        core_reset;
  logic [23:0] rom_mask;
  logic        load_done;
  logic        overflow;

`ifdef ROM_HDR_SKIP_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_load_arbiter #(.FIFO_DEPTH(4), .ROM_INDEX(8'h00)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_filesize(ioctl_filesize),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_ack(core_ack), .core_dout(core_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout),
    .core_reset(core_reset), .rom_mask(rom_mask), .load_done(load_done), .overflow(overflow)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          ack_delay = 1;
  logic        log_we[$];
  logic [23:0] log_addr[$];
  logic [15:0] log_din[$];

  function automatic logic [15:0] rd_data(input logic [23:0] a);
    return a[15:0] ^ a[23:8] ^ 16'h5A3C;
  endfunction

  // Byte mask = next power of two covering the image, minus one.
  function automatic logic [23:0] exp_mask(input int unsigned max_w);
    longint unsigned bytes, p;
    if (max_w == 0) return 24'd0;
    bytes = 2 * longint'(max_w);
    p = 1;
    while (p < bytes) p = p << 1;
    return 24'(p - 1);
  endfunction

  // SDRAM responder: acknowledges each request after ack_delay cycles.
  int resp_cnt = 0;
  always @(posedge clk_sys) begin
    #2;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      resp_cnt = 0;
    end else if (mem_req === 1'b1) begin
      if (resp_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_dout = rd_data(mem_addr);
        log_we.push_back(mem_we);
        log_addr.push_back(mem_addr);
        log_din.push_back(mem_din);
        $display("txn we=%0d addr=%06h din=%04h", mem_we, mem_addr, mem_din);
      end else begin
        resp_cnt++;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  int unsigned done_cnt = 0, core_ack_cnt = 0, core_ack_at_done = 0;
  int unsigned req_cyc = 0, cr_cyc = 0, proto_err = 0;
  logic        cr_at_done = 1'b0, cr_after = 1'b1, chk_after = 1'b0;
  logic [15:0] last_core_dout = '0;
  logic        prev_ack = 1'b0, prev_req = 1'b0, prev_we = 1'b0;
  logic [23:0] prev_addr = '0;
  logic [15:0] prev_din = '0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (prev_ack && mem_req) proto_err++;
      if (prev_req && mem_req && !prev_ack &&
          (mem_addr !== prev_addr || mem_din !== prev_din || mem_we !== prev_we)) proto_err++;
    end
    prev_ack  = mem_ack;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_din  = mem_din;
    prev_we   = mem_we;
    if (mem_req) req_cyc++;
    if (core_reset) cr_cyc++;
    if (core_ack) begin
      core_ack_cnt++;
      last_core_dout = core_dout;
    end
    if (chk_after) begin
      cr_after  = core_reset;
      chk_after = 1'b0;
    end
    if (load_done) begin
      done_cnt++;
      cr_at_done       = core_reset;
      chk_after        = 1'b1;
      core_ack_at_done = core_ack_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [23:0] fs, input int n,
                         input int unsigned base_w, input int unsigned stride,
                         input int gap, input bit expect_ovf);
    int unsigned log0, done0, max_w;
    int          bad, j;
    bit          hdr;
    logic [24:0] bytea;
    logic [15:0] d;
    logic [23:0] exp_a[$], got_a[$];
    logic [15:0] exp_d[$], got_d[$];
    log0  = log_addr.size();
    done0 = done_cnt;
    hdr   = HDR_EN && (fs[9:0] == 10'd512);
    ioctl_index = 8'h00;
    ioctl_filesize = fs;
    ioctl_download = 1'b1;
    tick();
    tick();
    check({tag, "_core_reset_in_load"}, core_reset, 1);
    check({tag, "_overflow_cleared"}, overflow, 0);
    for (int i = 0; i < n; i++) begin
      bytea = 25'((base_w + i * stride) * 2);
      d = 16'($urandom);
      ioctl_addr = bytea;
      ioctl_dout = d;
      ioctl_wr = ~ioctl_wr;
      if (!(hdr && bytea < 25'd512)) begin
        exp_a.push_back(hdr ? 24'(bytea[24:1] - 24'd256) : bytea[24:1]);
        exp_d.push_back(d);
      end
      repeat (gap) tick();
    end
    ioctl_download = 1'b0;
    for (int k = 0; k < 4000 && done_cnt == done0; k++) tick();
    repeat (3) tick();
    check({tag, "_load_done_once"}, done_cnt - done0, 1);
    check({tag, "_core_reset_at_done"}, cr_at_done, 1);
    check({tag, "_core_reset_after_done"}, cr_after, 0);
    for (int i = int'(log0); i < log_addr.size(); i++)
      if (log_we[i]) begin
        got_a.push_back(log_addr[i]);
        got_d.push_back(log_din[i]);
      end
    bad = 0;
    max_w = 0;
    if (!expect_ovf) begin
      check({tag, "_write_count"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) bad++;
      check({tag, "_write_contents"}, bad, 0);
      check({tag, "_overflow"}, overflow, 0);
      foreach (exp_a[i]) if (int'(exp_a[i]) + 1 > int'(max_w)) max_w = exp_a[i] + 1;
    end else begin
      j = 0;
      foreach (got_a[i]) begin
        while (j < exp_a.size() && exp_a[j] !== got_a[i]) j++;
        if (j >= exp_a.size()) bad++;
        else begin
          if (exp_d[j] !== got_d[i]) bad++;
          j++;
        end
      end
      check({tag, "_ordered_subset"}, bad, 0);
      check({tag, "_some_dropped"}, got_a.size() < exp_a.size(), 1);
      check({tag, "_overflow"}, overflow, 1);
      foreach (got_a[i]) if (int'(got_a[i]) + 1 > int'(max_w)) max_w = got_a[i] + 1;
    end
    check({tag, "_rom_mask"}, rom_mask, exp_mask(max_w));
  endtask

  task automatic core_access(input string tag, input logic we, input logic [23:0] a,
                             input logic [15:0] d);
    int unsigned c0, l0;
    c0 = core_ack_cnt;
    l0 = log_addr.size();
    core_we = we;
    core_addr = a;
    core_din = d;
    core_req = 1'b1;
    for (int k = 0; k < 100 && core_ack_cnt == c0; k++) tick();
    core_req = 1'b0;
    repeat (4) tick();
    check({tag, "_core_ack_once"}, core_ack_cnt - c0, 1);
    check({tag, "_mem_addr"}, (log_addr.size() > l0) ? log_addr[l0] : 24'hx, a);
    check({tag, "_mem_we"}, (log_we.size() > l0) ? log_we[l0] : 1'bx, we);
    if (we) check({tag, "_mem_din"}, (log_din.size() > l0) ? log_din[l0] : 16'hx, d);
    else    check({tag, "_core_dout"}, last_core_dout, rd_data(a));
  endtask

  initial begin
    int unsigned c0, done0, req0, cr0;
    logic [23:0] mask0;

    repeat (3) tick();
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_core_ack", core_ack, 0);
    check("reset_load_done", load_done, 0);
    check("reset_overflow", overflow, 0);
    check("reset_core_reset", core_reset, 1);
    check("reset_rom_mask", rom_mask, 24'hFFFFFF);
    reset = 1'b0;
    tick();
    tick();
    check("idle_core_reset_low", core_reset, 0);

    ack_delay = 2;
    do_load("basic", 24'h100000, 8, 0, 1, 6, 1'b0);

    ack_delay = 1;
    do_load("hdr", 24'h080200, 264, 0, 1, 6, 1'b0);

    ack_delay = 6;
    do_load("ovf", 24'h100000, 12, 0, 1, 1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      ack_delay = $urandom_range(0, 3);
      do_load($sformatf("rnd%0d", r), ($urandom_range(0, 1) != 0) ? 24'h100000 : 24'h040200,
              $urandom_range(1, 12), $urandom_range(0, 1 << 20), $urandom_range(1, 4000),
              ack_delay + 5, 1'b0);
      core_access($sformatf("core%0d", r), 1'($urandom_range(0, 1)), 24'($urandom),
                  16'($urandom));
    end

    // Core access in flight when the download begins.
    ack_delay = 5;
    core_we = 1'b0;
    core_addr = 24'h00ABCD;
    core_req = 1'b1;
    tick();
    tick();
    check("inflight_core_granted", mem_req, 1);
    c0 = core_ack_cnt;
    do_load("inflight", 24'h100000, 3, 100, 1, 10, 1'b0);
    check("inflight_acks_before_done", core_ack_at_done - c0, 1);
    for (int k = 0; k < 100 && core_ack_cnt < c0 + 2; k++) tick();
    core_req = 1'b0;
    repeat (4) tick();
    check("inflight_core_regranted", core_ack_cnt - c0, 2);

    // Non-matching index is ignored entirely.
    ack_delay = 1;
    done0 = done_cnt;
    req0 = req_cyc;
    cr0 = cr_cyc;
    mask0 = rom_mask;
    ioctl_index = 8'h01;
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'(i * 2);
      ioctl_dout = 16'($urandom);
      ioctl_wr = ~ioctl_wr;
      repeat (3) tick();
    end
    ioctl_download = 1'b0;
    repeat (10) tick();
    check("badidx_no_mem_req", req_cyc - req0, 0);
    check("badidx_no_core_reset", cr_cyc - cr0, 0);
    check("badidx_no_done", done_cnt - done0, 0);
    check("badidx_rom_mask", rom_mask, mask0);

    // Reset in the middle of a load with a request outstanding.
    ack_delay = 60;
    ioctl_index = 8'h00;
    ioctl_filesize = 24'h100000;
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i * 2);
      ioctl_dout = 16'($urandom);
      ioctl_wr = ~ioctl_wr;
      repeat (2) tick();
    end
    for (int k = 0; k < 20 && mem_req !== 1'b1; k++) tick();
    check("rst_mid_req_pending", mem_req, 1);
    done0 = done_cnt;
    reset = 1'b1;
    tick();
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_core_reset", core_reset, 1);
    check("rst_mid_load_done", load_done, 0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    req0 = req_cyc;
    repeat (20) tick();
    check("rst_mid_fifo_flushed", req_cyc - req0, 0);
    check("rst_mid_no_done", done_cnt - done0, 0);
    check("rst_mid_core_reset_rel", core_reset, 0);
    ack_delay = 1;

    check("mem_protocol", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
